// File: rtl/fifo_unpack_rd_if.sv
// fifo_unpack_rd_if: bundles the control, FIFO read-side and narrow output stream signals of
// fifo_unpack_rd.
//   start/cfg_words   transfer request and length in wide words
//   busy/done         transfer status (busy in RUN, one-cycle done pulse)
//   fifo_empty/data   FIFO first-word-fall-through head
//   fifo_pop          FIFO pop strobe
//   out_valid/data/last/ready  narrow valid/ready beat stream
// master: drives requests, FIFO head and out_ready (the surrounding system / bench).
// slave:  the converter itself.
interface fifo_unpack_rd_if #(
  parameter int unsigned IN_WIDTH  = 256,
  parameter int unsigned OUT_WIDTH = 64,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 start;
  logic [CNT_WIDTH-1:0] cfg_words;
  logic                 busy;
  logic                 done;
  logic                 fifo_empty;
  logic [IN_WIDTH-1:0]  fifo_data;
  logic                 fifo_pop;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;
  logic                 out_ready;

  modport master (
    output start, cfg_words, fifo_empty, fifo_data, out_ready,
    input  busy, done, fifo_pop, out_valid, out_data, out_last
  );

  modport slave (
    input  start, cfg_words, fifo_empty, fifo_data, out_ready,
    output busy, done, fifo_pop, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fifo_unpack_rd.sv
// fifo_unpack_rd: read-side width converter behind a wide FWFT FIFO.
// Pops one IN_WIDTH word into a holding register and emits it as RATIO OUT_WIDTH beats,
// LSB slice first. A start/done FSM bounds the transfer to cfg_words wide words and flags
// the final narrow beat with out_last.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fifo_unpack_rd_if.slave (control, FIFO read side, narrow output stream)
// The interface instance must be built with the same IN_WIDTH/OUT_WIDTH/CNT_WIDTH.
module fifo_unpack_rd #(
  parameter int unsigned IN_WIDTH   = 256,
  parameter int unsigned OUT_WIDTH  = 64,
  parameter int unsigned RATIO      = 4,
  parameter int unsigned log2_RATIO = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_unpack_rd_if.slave  bus
);

  localparam logic [log2_RATIO-1:0] SliceLast = log2_RATIO'(RATIO - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e r_state;
  state_e w_state_d;

  logic [CNT_WIDTH-1:0]  r_cfg_words;
  logic [CNT_WIDTH-1:0]  r_words_loaded;
  logic [CNT_WIDTH-1:0]  r_words_sent;
  logic [IN_WIDTH-1:0]   r_hold_data;
  logic                  r_hold_valid;
  logic [log2_RATIO-1:0] r_slice;

  logic                            w_run;
  logic                            w_accept;
  logic                            w_hs;
  logic                            w_slice_last;
  logic                            w_last_beat;
  logic                            w_load;
  logic [RATIO-1:0][OUT_WIDTH-1:0] w_slices;

  assign w_run        = (r_state == StRun);
  assign w_accept     = (r_state == StIdle) && bus.start;
  assign w_hs         = r_hold_valid && bus.out_ready;
  assign w_slice_last = (r_slice == SliceLast);
  assign w_last_beat  = r_hold_valid && w_slice_last &&
                        (r_words_sent == (r_cfg_words - CNT_WIDTH'(1)));

  // Reload is allowed on the handshake of the last slice so a non-empty FIFO gives no bubble.
  assign w_load = w_run && !bus.fifo_empty && (r_words_loaded < r_cfg_words) &&
                  (!r_hold_valid || (w_hs && w_slice_last));

  assign w_slices = r_hold_data;

  assign bus.busy      = w_run;
  assign bus.done      = (r_state == StDone);
  assign bus.fifo_pop  = w_load;
  assign bus.out_valid = r_hold_valid;
  assign bus.out_data  = w_slices[r_slice];
  assign bus.out_last  = w_last_beat;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_d = (bus.cfg_words != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (w_hs && w_last_beat) begin
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_words    <= '0;
      r_words_loaded <= '0;
      r_words_sent   <= '0;
      r_hold_data    <= '0;
      r_hold_valid   <= 1'b0;
      r_slice        <= '0;
    end else if (w_accept) begin
      r_cfg_words    <= bus.cfg_words;
      r_words_loaded <= '0;
      r_words_sent   <= '0;
      r_hold_valid   <= 1'b0;
      r_slice        <= '0;
    end else begin
      if (w_hs) begin
        if (w_slice_last) begin
          r_slice      <= '0;
          r_words_sent <= r_words_sent + CNT_WIDTH'(1);
          r_hold_valid <= 1'b0;
        end else begin
          r_slice <= r_slice + log2_RATIO'(1);
        end
      end
      // A load overrides the drop of hold_valid from a last-slice handshake above.
      if (w_load) begin
        r_hold_data    <= bus.fifo_data;
        r_hold_valid   <= 1'b1;
        r_slice        <= '0;
        r_words_loaded <= r_words_loaded + CNT_WIDTH'(1);
      end
    end
  end

endmodule
